// File: rtl/uart_cmd_ctrl_if.sv
// Purpose: bundles the UART byte-strobe input side and the command
//          valid/ready output side of uart_cmd_ctrl.
// Signals:
//   rx_done_tick, rx_data  - received byte strobe and data
//   cmd_valid, cmd_ready   - command handshake
//   cmd_op, cmd_arg        - command payload
//   busy                   - frame in progress
//   chk_err, timeout_err, ovf_err - one-cycle error pulses
// Modports: slave = the controller, master = the byte source / consumer.
interface uart_cmd_ctrl_if;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        chk_err;
  logic        timeout_err;
  logic        ovf_err;

  modport slave (
    input  rx_done_tick, rx_data, cmd_ready,
    output cmd_valid, cmd_op, cmd_arg, busy, chk_err, timeout_err, ovf_err
  );

  modport master (
    output rx_done_tick, rx_data, cmd_ready,
    input  cmd_valid, cmd_op, cmd_arg, busy, chk_err, timeout_err, ovf_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Purpose: assembles SYNC/OP/A0..A3/CHK command frames from UART bytes,
//          presents validated commands over valid/ready, and flags
//          checksum errors, inter-byte timeouts and overruns.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-low reset
//   bus   - uart_cmd_ctrl_if.slave (byte input, command output, error pulses)
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 500000
) (
  input  logic           clk,
  input  logic           reset,
  uart_cmd_ctrl_if.slave bus
);

  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_OP   = 3'd1,
    S_ARG  = 3'd2,
    S_CHK  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e        state_q;
  logic [1:0]    n_q;
  logic [7:0]    xor_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    op_q;
  logic [31:0]   arg_q;
  logic          valid_q;
  logic          busy_q;
  logic          chk_err_q;
  logic          timeout_err_q;
  logic          ovf_err_q;

  logic       rx;
  logic [7:0] din;
  logic       in_frame;
  logic       expire;

  assign rx       = bus.rx_done_tick;
  assign din      = bus.rx_data;
  assign in_frame = (state_q == S_OP) || (state_q == S_ARG) || (state_q == S_CHK);
  // A byte in the expiry cycle takes priority over the timeout.
  assign expire   = in_frame && !rx && (tmr_q == TMAX);

  // Frame FSM, timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_HUNT;
      n_q           <= '0;
      xor_q         <= '0;
      tmr_q         <= '0;
      op_q          <= '0;
      arg_q         <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;

      // Cleared at expiry as well so the counter never wraps.
      if (rx || !in_frame || (tmr_q == TMAX)) tmr_q <= '0;
      else                                     tmr_q <= tmr_q + TW'(1);

      if (expire) begin
        state_q       <= S_HUNT;
        busy_q        <= 1'b0;
        timeout_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_HUNT: begin
            if (rx && (din == SYNC_BYTE)) begin
              state_q <= S_OP;
              busy_q  <= 1'b1;
            end
          end
          S_OP: begin
            if (rx) begin
              op_q    <= din;
              xor_q   <= din;
              n_q     <= 2'd0;
              state_q <= S_ARG;
            end
          end
          S_ARG: begin
            if (rx) begin
              arg_q[{n_q, 3'b000} +: 8] <= din;
              xor_q <= xor_q ^ din;
              if (n_q == 2'd3) state_q <= S_CHK;
              else             n_q     <= n_q + 2'd1;
            end
          end
          S_CHK: begin
            if (rx) begin
              if (din == xor_q) begin
                state_q <= S_HOLD;
                valid_q <= 1'b1;
              end else begin
                state_q   <= S_HUNT;
                busy_q    <= 1'b0;
                chk_err_q <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (bus.cmd_ready) begin
              valid_q <= 1'b0;
              // Same-cycle byte is judged as if already back in HUNT.
              if (rx && (din == SYNC_BYTE)) begin
                state_q <= S_OP;
              end else begin
                state_q <= S_HUNT;
                busy_q  <= 1'b0;
              end
            end else if (rx) begin
              ovf_err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_HUNT;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_op      = op_q;
  assign bus.cmd_arg     = arg_q;
  assign bus.busy        = busy_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Purpose: self-checking bench for uart_cmd_ctrl; directed frames from the
//          test plan followed by randomized frames, all compared each cycle
//          against a frame-level reference model.
module tb_uart_cmd_ctrl;
  localparam int unsigned TO   = 8;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Stimulus controls
  logic rst_drv  = 1'b0;
  logic rdy      = 1'b0;
  logic rand_rdy = 1'b0;

  // Reference model state
  logic [7:0]  frame[$];
  logic        collecting = 1'b0;
  logic        holding    = 1'b0;
  int          idle       = 0;
  logic        known      = 1'b1;
  logic        exp_valid  = 1'b0;
  logic        exp_busy   = 1'b0;
  logic        exp_chk    = 1'b0;
  logic        exp_to     = 1'b0;
  logic        exp_ovf    = 1'b0;
  logic [7:0]  exp_op     = 8'h00;
  logic [31:0] exp_arg    = 32'h0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: one call per rising edge with the sampled inputs.
  task automatic model(input logic rx, input logic [7:0] d, input logic r, input logic rs);
    logic [7:0] x;
    exp_chk = 1'b0; exp_to = 1'b0; exp_ovf = 1'b0;
    if (!rs) begin
      collecting = 1'b0; holding = 1'b0; exp_valid = 1'b0;
      exp_op = 8'h00; exp_arg = 32'h0; known = 1'b1;
    end else if (holding) begin
      if (r) begin
        holding = 1'b0; exp_valid = 1'b0;
        if (rx && d == SYNC) begin
          collecting = 1'b1; frame.delete(); idle = 0; known = 1'b0;
        end
      end else if (rx) begin
        exp_ovf = 1'b1;
      end
    end else if (collecting) begin
      if (rx) begin
        frame.push_back(d);
        idle = 0;
        if (frame.size() == 6) begin
          x = 8'h00;
          for (int i = 0; i < 5; i++) x = x ^ frame[i];
          collecting = 1'b0;
          if (frame[5] == x) begin
            holding = 1'b1; exp_valid = 1'b1; known = 1'b1;
            exp_op  = frame[0];
            exp_arg = {frame[4], frame[3], frame[2], frame[1]};
          end else begin
            exp_chk = 1'b1;
          end
        end
      end else begin
        idle++;
        if (idle == TO) begin
          exp_to = 1'b1; collecting = 1'b0;
        end
      end
    end else if (rx && d == SYNC) begin
      collecting = 1'b1; frame.delete(); idle = 0; known = 1'b0;
    end
    exp_busy = collecting || holding;
  endtask

  task automatic check_outputs();
    cmp("cmd_valid",   32'(bus.cmd_valid),   32'(exp_valid));
    cmp("busy",        32'(bus.busy),        32'(exp_busy));
    cmp("chk_err",     32'(bus.chk_err),     32'(exp_chk));
    cmp("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
    cmp("ovf_err",     32'(bus.ovf_err),     32'(exp_ovf));
    if (known) begin
      cmp("cmd_op",  32'(bus.cmd_op), 32'(exp_op));
      cmp("cmd_arg", bus.cmd_arg,     exp_arg);
    end
  endtask

  // One clock: drive inputs, step model at the edge, check at the falling edge.
  task automatic step(input logic rx, input logic [7:0] d);
    if (rand_rdy) rdy = ($urandom_range(0, 2) == 0);
    bus.rx_done_tick = rx;
    bus.rx_data      = rx ? d : 8'($urandom);
    bus.cmd_ready    = rdy;
    reset            = rst_drv;
    @(posedge clk);
    model(rx, d, rdy, rst_drv);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic good_frame();
    send(SYNC); send(8'h10); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h18);
  endtask

  task automatic handshake();
    rdy = 1'b1; idle_cycles(1); rdy = 1'b0; idle_cycles(1);
  endtask

  task automatic rand_frame(input int gap_max);
    logic [7:0] b[7];
    b[0] = SYNC;
    for (int i = 1; i < 6; i++) b[i] = 8'($urandom);
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    if ($urandom_range(0, 4) == 0) b[6] = b[6] ^ 8'(1 << $urandom_range(0, 7));
    for (int i = 0; i < 7; i++) begin
      idle_cycles($urandom_range(0, gap_max));
      send(b[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.cmd_ready    = 1'b0;
    reset            = 1'b0;

    // Reset values
    rst_drv = 1'b0; idle_cycles(3);
    rst_drv = 1'b1; idle_cycles(1);

    // Good frame, consumer stalls 5 cycles
    good_frame();
    cmp("tp_good_valid", 32'(bus.cmd_valid), 32'h1);
    cmp("tp_good_op",    32'(bus.cmd_op),    32'h10);
    cmp("tp_good_arg",   bus.cmd_arg,        32'h12345678);
    idle_cycles(5);
    handshake();

    // Bad checksum, then good frame
    send(SYNC); send(8'h10); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h19);
    cmp("tp_bad_chk_err", 32'(bus.chk_err), 32'h1);
    cmp("tp_bad_busy",    32'(bus.busy),    32'h0);
    idle_cycles(2);
    good_frame();
    handshake();

    // Timeout after A5 10, then good frame
    send(SYNC); send(8'h10);
    idle_cycles(TO + 2);
    good_frame();
    handshake();

    // Timeout boundary: byte exactly in the expiry cycle is accepted
    send(SYNC); idle_cycles(TO - 1); send(8'h10);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h18);
    cmp("tp_edge_valid", 32'(bus.cmd_valid), 32'h1);
    handshake();

    // Overrun in HOLD, then ready coincident with next SYNC
    good_frame();
    idle_cycles(1);
    send(8'h33);
    cmp("tp_ovf", 32'(bus.ovf_err), 32'h1);
    cmp("tp_ovf_arg", bus.cmd_arg, 32'h12345678);
    idle_cycles(1);
    rdy = 1'b1; send(SYNC); rdy = 1'b0;
    send(8'h10); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h18);
    cmp("tp_b2b_valid", 32'(bus.cmd_valid), 32'h1);
    handshake();

    // Noise in HUNT
    send(8'h00); send(8'hFF); send(8'h5A);
    good_frame();
    handshake();

    // Reset mid-ARG
    send(SYNC); send(8'h10); send(8'h78); send(8'h56);
    rst_drv = 1'b0; idle_cycles(1); rst_drv = 1'b1;
    cmp("tp_rst_arg_busy", 32'(bus.busy), 32'h0);
    idle_cycles(1);
    // Reset in HOLD
    good_frame();
    idle_cycles(2);
    rst_drv = 1'b0; idle_cycles(1); rst_drv = 1'b1;
    cmp("tp_rst_hold_valid", 32'(bus.cmd_valid), 32'h0);
    idle_cycles(1);
    good_frame();
    handshake();

    // Randomized frames, gaps, noise, ready and occasional reset
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom));
      rand_frame((k % 5 == 0) ? TO + 1 : 3);
      idle_cycles($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        rst_drv = 1'b0; idle_cycles(1); rst_drv = 1'b1;
      end
    end
    rand_rdy = 1'b0;
    rdy = 1'b1; idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
